// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    // Upper bound on requester count supported by the one-hot helper
    localparam int MAX_N = 1024;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Number of requesters served for a given sel width
    function automatic int num_req(input int select_bit);
        return 1 << select_bit;
    endfunction

    // One-hot encoding of an index, truncated by the caller to N bits
    function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_priority_pick.sv
// Combinational round-robin winner search: scans ptr, ptr+1, ... (mod N)
// over the requests that are not excluded and returns the first hit.
module rr_mux_arbiter_rr_priority_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int SELECT_BIT = 2,
    localparam int N = num_req(SELECT_BIT)
) (
    input  logic [N-1:0]          req,
    input  logic [SELECT_BIT-1:0] ptr,
    input  logic [N-1:0]          excl,
    output logic [SELECT_BIT-1:0] win,
    output logic                  found
);

    logic [N-1:0]          cand;
    logic [SELECT_BIT-1:0] idx;

    assign cand = req & ~excl;

    // Walk offsets from farthest to nearest so the nearest-to-ptr hit wins
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + SELECT_BIT'(k);
            if (cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared N:1 mux.
// Optional owner pre-emption is enabled by defining ARB_TIMEOUT_EN.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int SELECT_BIT     = 2,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int N = num_req(SELECT_BIT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    output logic [N-1:0]          gnt,
    output logic                  gnt_valid,
    output logic [SELECT_BIT-1:0] sel,
    output logic                  timeout
);

    state_t                state;
    logic [SELECT_BIT-1:0] ptr;
    logic [SELECT_BIT-1:0] win;
    logic                  found;
    logic [N-1:0]          excl;
    logic                  owner_holds;
    logic                  others_wait;
    logic                  preempt;
    logic                  take;

    // In GRANT, sel always names the owner
    assign owner_holds = (state == GRANT) && req[sel];
    assign others_wait = |(req & ~gnt);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] hold_cnt;
    logic          cnt_full;

    assign cnt_full = (hold_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign preempt  = owner_holds && cnt_full && others_wait;

    // Hold counter restarts on each new grant and saturates at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= take && preempt;
            if (take)
                hold_cnt <= '0;
            else if (owner_holds && !cnt_full)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign preempt = 1'b0;
    assign timeout = 1'b0;
`endif

    // A pre-empted owner is kept out of the search; otherwise its request is
    // already low or it is not being re-arbitrated
    assign excl = preempt ? gnt : '0;

    rr_mux_arbiter_rr_priority_pick #(
        .SELECT_BIT (SELECT_BIT)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .excl  (excl),
        .win   (win),
        .found (found)
    );

    // A new owner is installed from IDLE, on owner release, or on pre-emption
    assign take = found && ((state == IDLE) || !owner_holds || preempt);

    // Arbitration FSM with registered grant, select and priority pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            sel       <= '0;
        end else if (take) begin
            state     <= GRANT;
            gnt       <= N'(onehot(32'(win)));
            gnt_valid <= 1'b1;
            sel       <= win;
            ptr       <= win + 1'b1;
        end else if ((state == GRANT) && !owner_holds) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end
    end

endmodule
